// File: rtl/acltx_arqsrc_pkg.sv
// rtl/acltx_arqsrc_pkg.sv - shared encodings for the ACL TX ARQ source
package acltx_arqsrc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_WAIT0 = 3'd4
  } ctx_state_t;

  localparam logic [1:0] PKTSEL_NULL = 2'b00;
  localparam logic [1:0] PKTSEL_NEW  = 2'b01;
  localparam logic [1:0] PKTSEL_RETX = 2'b10;
  localparam logic [1:0] PKTSEL_CONT = 2'b11;
  localparam logic [1:0] LLID_CONT   = 2'b01;

  // A context still owns the host buffer only while READY or WAIT
  function automatic logic owns_buf(ctx_state_t s);
    return (s == ST_READY) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/acltx_lt_ctx.sv
// rtl/acltx_lt_ctx.sv - one LT_ADDR retransmission context
module acltx_lt_ctx
  import acltx_arqsrc_pkg::*;
#(
  parameter int LENW = 10,
  parameter int TOW  = 16
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            sel,
  input  logic            connsnew,
  input  logic            load_hit,
  input  logic [LENW-1:0] load_len,
  input  logic [1:0]      load_llid,
  input  logic            flush_cmd,
  input  logic [TOW-1:0]  flush_to,
  input  logic            slot_p,
  input  logic            tx_slot_p,
  input  logic            rx_done_p,
  input  logic            rx_hdr_valid,
  input  logic            rx_arqn,
  input  logic            rx_flow,
  output logic [1:0]      tx_pktsel,
  output logic            tx_seqn,
  output logic [LENW-1:0] tx_len,
  output logic [1:0]      tx_llid,
  output logic            free_p,
  output logic            load_ok,
  output logic            busy
);

  ctx_state_t      state, state_nx, cur;
  logic            seqn, seqn_nx;
  logic            flow_stop, flow_nx;
  logic [LENW-1:0] len_q;
  logic [1:0]      llid_q;
  logic [TOW-1:0]  to_cnt, to_cnt_nx;
  logic            timed_out;

  assign busy      = (state != ST_IDLE);
  assign timed_out = (flush_to != '0) && (to_cnt >= flush_to) && owns_buf(state);

  // Context registers
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state     <= ST_IDLE;
      seqn      <= 1'b0;
      flow_stop <= 1'b0;
      len_q     <= '0;
      llid_q    <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nx;
      seqn      <= seqn_nx;
      flow_stop <= flow_nx;
      to_cnt    <= to_cnt_nx;
      if (load_ok) begin
        len_q  <= load_len;
        llid_q <= load_llid;
      end
    end
  end

  // Next state and slot decision; events on this LT are taken in priority order
  always_comb begin
    state_nx  = state;
    seqn_nx   = seqn;
    flow_nx   = flow_stop;
    free_p    = 1'b0;
    cur       = state;
    tx_pktsel = PKTSEL_NULL;
    tx_seqn   = seqn;
    tx_len    = '0;
    tx_llid   = '0;
    if (sel && connsnew) begin
      state_nx = ST_IDLE;
      seqn_nx  = 1'b0;
      flow_nx  = 1'b0;
      free_p   = owns_buf(state);
    end else if (sel && rx_done_p) begin
      // An invalid header is an implicit NAK and carries no usable FLOW bit
      if (rx_hdr_valid) begin
        flow_nx = !rx_flow;
        if (rx_arqn && state == ST_WAIT) begin
          state_nx = ST_IDLE;
          free_p   = 1'b1;
        end else if (rx_arqn && state == ST_WAIT0) begin
          state_nx = ST_IDLE;
        end
      end
    end else if (sel && (flush_cmd || tx_slot_p)) begin
      // Auto-flush is resolved first so the same slot already sees the flushed state
      if (flush_cmd || timed_out) begin
        if (state == ST_READY) begin
          cur    = ST_IDLE;
          free_p = 1'b1;
        end else if (state == ST_WAIT) begin
          cur    = ST_FLUSH;
          free_p = 1'b1;
        end
      end
      state_nx = cur;
      if (!flush_cmd && !flow_stop) begin
        case (cur)
          ST_READY: begin
            seqn_nx   = !seqn;
            tx_seqn   = !seqn;
            tx_pktsel = PKTSEL_NEW;
            tx_len    = len_q;
            tx_llid   = llid_q;
            state_nx  = ST_WAIT;
          end
          ST_WAIT: begin
            tx_pktsel = PKTSEL_RETX;
            tx_len    = len_q;
            tx_llid   = llid_q;
          end
          ST_FLUSH: begin
            seqn_nx   = !seqn;
            tx_seqn   = !seqn;
            tx_pktsel = PKTSEL_CONT;
            tx_llid   = LLID_CONT;
            state_nx  = ST_WAIT0;
          end
          ST_WAIT0: begin
            tx_pktsel = PKTSEL_CONT;
            tx_llid   = LLID_CONT;
          end
          default: ;
        endcase
      end
    end
    // A load is only taken by an idle context that is not being reset this cycle
    load_ok = load_hit && (state == ST_IDLE) && !(sel && connsnew);
    if (load_ok) state_nx = ST_READY;
    to_cnt_nx = to_cnt;
    if (state_nx == ST_IDLE || load_ok) begin
      to_cnt_nx = '0;
    end else if (slot_p && owns_buf(state) && to_cnt != '1) begin
      to_cnt_nx = to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acltx_arqsrc.sv
// rtl/acltx_arqsrc.sv - ACL-U transmit ARQ source, one context per LT_ADDR
module acltx_arqsrc
  import acltx_arqsrc_pkg::*;
#(
  parameter int NLT  = 8,
  parameter int LENW = 10,
  parameter int TOW  = 16
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic [2:0]      ms_lt_addr,
  input  logic            connsnew,
  input  logic            pkt_load_p,
  input  logic [2:0]      load_lt_addr,
  input  logic [LENW-1:0] load_len,
  input  logic [1:0]      load_llid,
  input  logic            regi_flushcmd_p,
  input  logic [TOW-1:0]  flush_to,
  input  logic            slot_p,
  input  logic            tx_slot_p,
  input  logic            rx_done_p,
  input  logic            rx_hdr_valid,
  input  logic            rx_arqn,
  input  logic            rx_flow,
  output logic [1:0]      tx_pktsel,
  output logic            tx_seqn,
  output logic [LENW-1:0] tx_len,
  output logic [1:0]      tx_llid,
  output logic            buf_free_p,
  output logic [2:0]      buf_free_lt,
  output logic            load_err_p,
  output logic [NLT-1:0]  pending
);

  logic [1:0]      c_pktsel [NLT];
  logic            c_seqn   [NLT];
  logic [LENW-1:0] c_len    [NLT];
  logic [1:0]      c_llid   [NLT];
  logic [NLT-1:0]  c_free;
  logic [NLT-1:0]  c_load_ok;

  for (genvar i = 0; i < NLT; i++) begin : g_ctx
    acltx_lt_ctx #(.LENW(LENW), .TOW(TOW)) u_ctx (
      .clk_6M       (clk_6M),
      .rstz         (rstz),
      .sel          (ms_lt_addr == 3'(i)),
      .connsnew     (connsnew),
      .load_hit     (pkt_load_p && load_lt_addr == 3'(i)),
      .load_len     (load_len),
      .load_llid    (load_llid),
      .flush_cmd    (regi_flushcmd_p),
      .flush_to     (flush_to),
      .slot_p       (slot_p),
      .tx_slot_p    (tx_slot_p),
      .rx_done_p    (rx_done_p),
      .rx_hdr_valid (rx_hdr_valid),
      .rx_arqn      (rx_arqn),
      .rx_flow      (rx_flow),
      .tx_pktsel    (c_pktsel[i]),
      .tx_seqn      (c_seqn[i]),
      .tx_len       (c_len[i]),
      .tx_llid      (c_llid[i]),
      .free_p       (c_free[i]),
      .load_ok      (c_load_ok[i]),
      .busy         (pending[i])
    );
  end

  // Slot decision is captured on tx_slot_p and held; free/error are one-cycle pulses
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      tx_pktsel   <= PKTSEL_NULL;
      tx_seqn     <= 1'b0;
      tx_len      <= '0;
      tx_llid     <= '0;
      buf_free_p  <= 1'b0;
      buf_free_lt <= '0;
      load_err_p  <= 1'b0;
    end else begin
      if (tx_slot_p) begin
        tx_pktsel <= c_pktsel[ms_lt_addr];
        tx_seqn   <= c_seqn[ms_lt_addr];
        tx_len    <= c_len[ms_lt_addr];
        tx_llid   <= c_llid[ms_lt_addr];
      end
      buf_free_p <= |c_free;
      if (|c_free) buf_free_lt <= ms_lt_addr;
      load_err_p <= pkt_load_p && !(|c_load_ok);
    end
  end

endmodule
